score_counter: RTL and testbench
================================

# score_counter

Score source for the chimp-test game's four-digit seven-segment display. The block takes raw push-button inputs and turns each clean press into a one-cycle event. A four-digit BCD score counter (0000–9999) consumes these events, and its digits drive the display's per-digit decoders directly. It sits between the board buttons and the display path, in the same clock domain.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: consecutive cycles a synchronized button level must hold before it is accepted. This is 10 ms at 100 MHz. Legal range is 2 or greater.
- SAT_AT_MAX, default 1: 1 makes the counter saturate at 9999; 0 makes it wrap to 0000.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- btn_inc  in  1  raw, asynchronous, bouncing button; a press adds 1
- btn_clr  in  1  raw, asynchronous, bouncing button; a press clears the score
- digit3  out  4  BCD thousands
- digit2  out  4  BCD hundreds
- digit1  out  4  BCD tens
- digit0  out  4  BCD ones
- at_max  out  1  high while the score equals 9999
- overflow  out  1  sticky; set when an increment occurs at 9999; cleared by rst or a clear press

## Operation
- Each button path is a 2-flop synchronizer, then a debouncer, then a rising-edge detector. The result is a one-cycle press pulse (inc_p, clr_p).
- The debouncer holds an accepted level `stable`, reset value 0.
  - Counter cnt has width $clog2(DEBOUNCE_CYCLES+1).
  - While the synchronized level equals `stable`, cnt is 0.
  - While it differs, cnt increments each cycle.
  - When cnt reaches DEBOUNCE_CYCLES−1 and the level still differs, `stable` takes the level and cnt returns to 0.
  - A glitch shorter than DEBOUNCE_CYCLES resets cnt to 0 and produces no pulse.
- A press pulse fires on the 0→1 transition of `stable` only. A release (1→0) produces no pulse.
- Score update, evaluated in the press-pulse cycle:
  - clr_p: all digits go to 0 and overflow goes to 0. Clear wins if clr_p and inc_p fire in the same cycle.
  - inc_p: BCD increment. A digit at 9 rolls to 0 and carries to the next digit.
  - inc_p at 9999 with SAT_AT_MAX=1: the score holds at 9999 and overflow is set.
  - inc_p at 9999 with SAT_AT_MAX=0: the score becomes 0000 and overflow is set.
- at_max is combinational from the digits: (digit3..digit0 == 9,9,9,9).
- Outputs are always legal BCD; the digit values 10–15 never occur.
- Reset values:
  - digits 0000; at_max 0; overflow 0.
  - synchronizer flops 0; `stable` 0; debounce counters 0; edge-detect registers 0.
- Reset mid-operation:
  - Reset clears everything in the same edge and discards in-progress debounce counts.
  - A button still held when rst deasserts is accepted as a new press after a full debounce interval.

## Timing
- All state updates on the rising edge of clk. rst is sampled only at clock edges.
- Latency is measured from the first edge at which the raw input is sampled high (edge 0), with no bouncing:
  - synchronized level high after edge 1;
  - `stable` high after edge DEBOUNCE_CYCLES+1;
  - press pulse high for exactly one cycle, after edge DEBOUNCE_CYCLES+2;
  - digits updated after edge DEBOUNCE_CYCLES+3.
- A button held indefinitely produces exactly one press.
- The next press requires a debounced release, then a debounced press.
- Both buttons are independent. Presses on both buttons, in any order and with any overlap, each take effect in their own pulse cycle.

## Structure
- Shared package score_pkg holds:
  - typedef bcd_digit_t (logic [3:0]);
  - constant BCD_MAX = 4'd9;
  - constant SCORE_DIGITS = 4.
- Sub-module button_debouncer (parameter DEBOUNCE_CYCLES; ports clk, rst, btn_raw, press_pulse) is instantiated twice. It contains the synchronizer, the debouncer and the edge detect.
- The top level holds the BCD digit registers, the carry chain, the overflow flag and the at_max decode.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Clean press: btn_inc high at edge 0 and held 20 cycles, from score 0000. Expect one inc pulse after edge 6, digits 0001 after edge 7, and no further change while held.
- Bounce rejection: btn_inc toggles high 2 cycles, low 1, high 3, low, repeated for 30 cycles with no run of 4 or more. Expect the score unchanged at 0000 and no pulse.
- Carry chain: preload 0999 via 999 presses, then press once. Expect 1000. Also check 0009→0010 and 0099→0100.
- Saturation and wrap:
  - SAT_AT_MAX=1, score 9999, press inc: expect 9999, at_max=1, overflow=1.
  - Then press clr: expect 0000, at_max=0, overflow=0.
  - Repeat with SAT_AT_MAX=0: expect 0000 with overflow=1.
- Simultaneous events: drive btn_inc and btn_clr identically so both pulses coincide at score 0042. Expect 0000.
- Reset mid-debounce: btn_inc held; assert rst at edge 3 for one cycle.
  - Expect all outputs 0 at the reset edge.
  - With btn_inc still held, expect the press accepted, digits 0001, exactly DEBOUNCE_CYCLES+3 edges after rst deasserts.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the four-digit BCD score path.
package score_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX      = 4'd9;
  localparam int         SCORE_DIGITS = 4;

endpackage

// File: rtl/button_debouncer.sv
// Raw push-button to one-cycle press pulse: 2-flop synchronizer, level debouncer,
// rising-edge detect. Only a debounced 0->1 transition of the accepted level pulses.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_prev_q;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count only runs while the synchronized level disagrees with the accepted one,
  // so any agreeing sample (a glitch ending) restarts the interval from zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = stable_q & ~stable_prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      pulse_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= btn_raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      pulse_q       <= pulse_d;
      cnt_q         <= cnt_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/score_counter.sv
// Four-digit BCD score counter fed by debounced increment and clear buttons;
// digits drive the seven-segment decoders directly.
module score_counter
  import score_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit SAT_AT_MAX      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_clr,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       at_max,
  output logic       overflow
);

  logic inc_p, clr_p;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_btn (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_inc),
    .press_pulse (inc_p)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_btn (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_clr),
    .press_pulse (clr_p)
  );

  bcd_digit_t [SCORE_DIGITS-1:0] dig_q, dig_d;
  logic                          ovf_q, ovf_d;
  logic                          at_max_w;
  logic                          carry;

  always_comb begin
    at_max_w = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (dig_q[i] != BCD_MAX) at_max_w = 1'b0;
    end
  end

  // Clear has priority over a coincident increment.
  always_comb begin
    dig_d = dig_q;
    ovf_d = ovf_q;
    carry = 1'b0;
    if (clr_p) begin
      dig_d = '0;
      ovf_d = 1'b0;
    end else if (inc_p) begin
      if (at_max_w) begin
        ovf_d = 1'b1;
        if (!SAT_AT_MAX) dig_d = '0;
      end else begin
        carry = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
          if (carry) begin
            if (dig_q[i] == BCD_MAX) begin
              dig_d[i] = '0;
            end else begin
              dig_d[i] = dig_q[i] + 4'd1;
              carry    = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      dig_q <= dig_d;
      ovf_q <= ovf_d;
    end
  end

  assign digit3   = dig_q[3];
  assign digit2   = dig_q[2];
  assign digit1   = dig_q[1];
  assign digit0   = dig_q[0];
  assign at_max   = at_max_w;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: saturating and wrapping instances share stimulus and are
// compared against an integer score model with a sample-window debounce model.
module tb_score_counter;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst, btn_inc, btn_clr;
  logic [3:0] s_d3, s_d2, s_d1, s_d0, w_d3, w_d2, w_d1, w_d0;
  logic s_at_max, s_ovf, w_at_max, w_ovf;
  logic [17:0] obs_s, obs_w;

  int checks = 0;
  int errors = 0;
  int score_s = 0, score_w = 0;
  bit ovf_s = 1'b0, ovf_w = 1'b0;

  always #5 clk = ~clk;

  score_counter #(.DEBOUNCE_CYCLES(DEB), .SAT_AT_MAX(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_clr(btn_clr),
    .digit3(s_d3), .digit2(s_d2), .digit1(s_d1), .digit0(s_d0),
    .at_max(s_at_max), .overflow(s_ovf)
  );

  score_counter #(.DEBOUNCE_CYCLES(DEB), .SAT_AT_MAX(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_clr(btn_clr),
    .digit3(w_d3), .digit2(w_d2), .digit1(w_d1), .digit0(w_d0),
    .at_max(w_at_max), .overflow(w_ovf)
  );

  assign obs_s = {s_d3, s_d2, s_d1, s_d0, s_at_max, s_ovf};
  assign obs_w = {w_d3, w_d2, w_d1, w_d0, w_at_max, w_ovf};

  // {thousands, hundreds, tens, ones, at_max, overflow}
  function automatic logic [17:0] expect_vec(input int score, input bit ovf);
    logic [15:0] b;
    b = {4'(score / 1000), 4'((score / 100) % 10), 4'((score / 10) % 10), 4'(score % 10)};
    return {b, (score == 9999), ovf};
  endfunction

  task model_inc();
    if (score_s == 9999) ovf_s = 1'b1;
    else score_s = score_s + 1;
    if (score_w == 9999) begin
      score_w = 0;
      ovf_w   = 1'b1;
    end else begin
      score_w = score_w + 1;
    end
  endtask

  task model_clr();
    score_s = 0; ovf_s = 1'b0;
    score_w = 0; ovf_w = 1'b0;
  endtask

  // Called at a negedge; minimal accepted press: 4 samples high, 4 low. Ends at the
  // negedge right after the score update edge.
  task automatic press(input bit inc, input bit clr);
    btn_inc = inc;
    btn_clr = clr;
    repeat (DEB) @(negedge clk);
    btn_inc = 1'b0;
    btn_clr = 1'b0;
    repeat (DEB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    btn_inc = 1'b0;
    btn_clr = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 2;
    if (obs_s !== expect_vec(0, 1'b0)) begin
      errors++; $display("FAIL reset_sat got %h want %h", obs_s, expect_vec(0, 1'b0));
    end
    if (obs_w !== expect_vec(0, 1'b0)) begin
      errors++; $display("FAIL reset_wrap got %h want %h", obs_w, expect_vec(0, 1'b0));
    end
    rst = 1'b0;
    model_clr();
    @(negedge clk);
  endtask

  task automatic test_clean_press();
    logic [17:0] exp;
    btn_inc = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp = expect_vec((k >= DEB + 3) ? 1 : 0, 1'b0);
      checks++;
      if (obs_s !== exp) begin
        errors++; $display("FAIL clean_press edge %0d got %h want %h", k, obs_s, exp);
      end
    end
    model_inc();
    idle(10);
    checks += 2;
    if (obs_s !== expect_vec(score_s, ovf_s)) begin
      errors++; $display("FAIL clean_release_sat got %h want %h", obs_s, expect_vec(score_s, ovf_s));
    end
    if (obs_w !== expect_vec(score_w, ovf_w)) begin
      errors++; $display("FAIL clean_release_wrap got %h want %h", obs_w, expect_vec(score_w, ovf_w));
    end
  endtask

  task automatic test_bounce();
    bit pat [7] = '{1, 1, 0, 1, 1, 1, 0};
    for (int k = 0; k < 30; k++) begin
      btn_inc = pat[k % 7];
      @(negedge clk);
      checks++;
      if (obs_s !== expect_vec(score_s, ovf_s)) begin
        errors++; $display("FAIL bounce cycle %0d got %h want %h", k, obs_s, expect_vec(score_s, ovf_s));
      end
    end
    idle(10);
    checks++;
    if (obs_s !== expect_vec(score_s, ovf_s)) begin
      errors++; $display("FAIL bounce_settle got %h want %h", obs_s, expect_vec(score_s, ovf_s));
    end
  endtask

  task automatic test_simultaneous();
    press(1'b0, 1'b1);
    model_clr();
    for (int i = 0; i < 42; i++) begin
      press(1'b1, 1'b0);
      model_inc();
    end
    checks++;
    if (obs_s !== expect_vec(42, 1'b0)) begin
      errors++; $display("FAIL preload_42 got %h want %h", obs_s, expect_vec(42, 1'b0));
    end
    press(1'b1, 1'b1);
    model_clr();
    checks += 2;
    if (obs_s !== expect_vec(0, 1'b0)) begin
      errors++; $display("FAIL simultaneous_sat got %h want %h", obs_s, expect_vec(0, 1'b0));
    end
    if (obs_w !== expect_vec(0, 1'b0)) begin
      errors++; $display("FAIL simultaneous_wrap got %h want %h", obs_w, expect_vec(0, 1'b0));
    end
  endtask

  // A level is accepted once the last DEB raw samples all equal it and differ from
  // the accepted level; a press is an acceptance of 1.
  task automatic test_random();
    logic [DEB-1:0] hist_i, hist_c;
    int n_i, n_c, left_i, left_c;
    bit st_i, st_c, ev_i, ev_c;
    idle(10);
    hist_i = '0; hist_c = '0; n_i = 0; n_c = 0;
    st_i = 1'b0; st_c = 1'b0; left_i = 0; left_c = 0;
    for (int r = 0; r < 8; r++) begin
      for (int cyc = 0; cyc < 76; cyc++) begin
        if (cyc < 64) begin
          if (left_i == 0) begin
            btn_inc = 1'($urandom_range(0, 1)); left_i = $urandom_range(1, 7);
          end
          if (left_c == 0) begin
            btn_clr = (($urandom_range(0, 3)) == 0); left_c = $urandom_range(1, 7);
          end
          left_i--; left_c--;
        end else begin
          btn_inc = 1'b0; btn_clr = 1'b0; left_i = 0; left_c = 0;
        end
        hist_i = {hist_i[DEB-2:0], btn_inc};
        hist_c = {hist_c[DEB-2:0], btn_clr};
        if (n_i < DEB) n_i++;
        if (n_c < DEB) n_c++;
        ev_i = 1'b0; ev_c = 1'b0;
        if (n_i == DEB && btn_inc != st_i && hist_i == {DEB{btn_inc}}) begin
          st_i = btn_inc; ev_i = btn_inc;
        end
        if (n_c == DEB && btn_clr != st_c && hist_c == {DEB{btn_clr}}) begin
          st_c = btn_clr; ev_c = btn_clr;
        end
        if (ev_c) model_clr();
        else if (ev_i) model_inc();
        @(negedge clk);
      end
      checks += 2;
      if (obs_s !== expect_vec(score_s, ovf_s)) begin
        errors++; $display("FAIL random_sat round %0d got %h want %h", r, obs_s, expect_vec(score_s, ovf_s));
      end
      if (obs_w !== expect_vec(score_w, ovf_w)) begin
        errors++; $display("FAIL random_wrap round %0d got %h want %h", r, obs_w, expect_vec(score_w, ovf_w));
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [17:0] exp;
    if (score_s == 0) begin
      press(1'b1, 1'b0);
      model_inc();
    end
    idle(4);
    btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (obs_s !== expect_vec(0, 1'b0)) begin
      errors++; $display("FAIL mid_reset_sat got %h want %h", obs_s, expect_vec(0, 1'b0));
    end
    if (obs_w !== expect_vec(0, 1'b0)) begin
      errors++; $display("FAIL mid_reset_wrap got %h want %h", obs_w, expect_vec(0, 1'b0));
    end
    rst = 1'b0;
    model_clr();
    for (int k = 0; k < DEB + 4; k++) begin
      @(negedge clk);
      exp = expect_vec((k >= DEB + 3) ? 1 : 0, 1'b0);
      checks++;
      if (obs_s !== exp) begin
        errors++; $display("FAIL held_after_reset edge %0d got %h want %h", k, obs_s, exp);
      end
    end
    model_inc();
    idle(10);
  endtask

  task automatic test_saturation();
    while (score_s < 9999) begin
      press(1'b1, 1'b0);
      model_inc();
      checks += 2;
      if (obs_s !== expect_vec(score_s, ovf_s)) begin
        errors++; $display("FAIL climb_sat got %h want %h", obs_s, expect_vec(score_s, ovf_s));
      end
      if (obs_w !== expect_vec(score_w, ovf_w)) begin
        errors++; $display("FAIL climb_wrap got %h want %h", obs_w, expect_vec(score_w, ovf_w));
      end
    end
    press(1'b1, 1'b0);
    model_inc();
    checks += 2;
    if (obs_s !== expect_vec(9999, 1'b1)) begin
      errors++; $display("FAIL saturate got %h want %h", obs_s, expect_vec(9999, 1'b1));
    end
    if (obs_w !== expect_vec(0, 1'b1)) begin
      errors++; $display("FAIL wrap got %h want %h", obs_w, expect_vec(0, 1'b1));
    end
    press(1'b0, 1'b1);
    model_clr();
    checks += 2;
    if (obs_s !== expect_vec(0, 1'b0)) begin
      errors++; $display("FAIL clear_after_sat got %h want %h", obs_s, expect_vec(0, 1'b0));
    end
    if (obs_w !== expect_vec(0, 1'b0)) begin
      errors++; $display("FAIL clear_after_wrap got %h want %h", obs_w, expect_vec(0, 1'b0));
    end
  endtask

  initial begin
    rst     = 1'b1;
    btn_inc = 1'b0;
    btn_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_random();
    test_reset_mid_debounce();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
